datapath_controller: RTL and testbench

//  Control FSM driving the datapath's control ports. Latches a 16-bit instruction, decodes fields
//  and immediates, and sequences readnum/loada/loadb/asel/bsel/shift/ALUop/loadc/loads/vsel/writenum/write
//  one stage per cycle. Sits between the instruction source (switches/bench) and datapath.

---
 rtl/datapath_ctrl_pkg.sv | 55 +++++
 rtl/datapath_controller_decoder.sv | 23 ++
 rtl/datapath_controller.sv | 129 ++++++++++++
 tb/tb_datapath_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared encodings and decoded-instruction layout for the datapath controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package datapath_ctrl_pkg;

  // Controller states, one datapath stage per cycle
  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  // Instruction classes (IR[15:13])
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Sub-operations (IR[12:11]); ADD/AND pass straight through to ALUop
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Writeback mux selects
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  // ALU operations forced by the controller (others come from op)
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Decoded view of the instruction register
  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
  } ir_fields_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/datapath_controller_decoder.sv
// Splits the instruction register into fields and sign-extended immediates.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows IR continuously.
module instruction_decoder
  import datapath_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output ir_fields_t  fields
);

  // Pure field extraction; immediates are sign-extended from the low IR bits
  always_comb begin
    fields.opcode = ir[15:13];
    fields.op     = ir[12:11];
    fields.rn     = ir[10:8];
    fields.rd     = ir[7:5];
    fields.sh     = ir[4:3];
    fields.rm     = ir[2:0];
    fields.sximm5 = sext5(ir[4:0]);
    fields.sximm8 = sext8(ir[7:0]);
  end

endmodule

// File: rtl/datapath_controller.sv
// Sequences datapath control enables for one latched 16-bit instruction, one stage per cycle.
// Latency: s edge to w=1 is 2 (MOV imm), 4 (MOV reg/MVN/CMP), 5 (ADD/AND), 1 (unsupported) cycles.
// Backpressure: w=0 while busy; load and s are ignored outside WAIT.
module datapath_controller
  import datapath_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;
  ir_fields_t  f;

  instruction_decoder u_dec (
    .ir     (ir),
    .fields (f)
  );

  assign sximm8 = f.sximm8;
  assign sximm5 = f.sximm5;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_WAIT;
    else       state <= next_state;
  end

  // Instruction register: loads only while idle, so a busy sequence never sees IR change
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         ir <= '0;
    else if (state == S_WAIT && load)  ir <= in;
  end

  // Next-state and Moore outputs; every control is 0 unless its stage asserts it
  always_comb begin
    next_state = state;
    w          = 1'b0;
    readnum    = 3'd0;
    writenum   = 3'd0;
    write      = 1'b0;
    vsel       = VSEL_C;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    shift      = 2'b00;
    ALUop      = ALU_ADD;
    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (f.opcode == OPC_MOV && f.op == OP_MOV_IMM)      next_state = S_WRITE_IMM;
        else if (f.opcode == OPC_MOV && f.op == OP_MOV_REG) next_state = S_GET_B;
        else if (f.opcode == OPC_ALU && f.op == OP_MVN)     next_state = S_GET_B;
        else if (f.opcode == OPC_ALU)                       next_state = S_GET_A;
        else                                                next_state = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum   = f.rn;
        vsel       = VSEL_IMM8;
        write      = 1'b1;
        next_state = S_WAIT;
      end
      S_GET_A: begin
        readnum    = f.rn;
        loada      = 1'b1;
        next_state = S_GET_B;
      end
      S_GET_B: begin
        readnum    = f.rm;
        loadb      = 1'b1;
        next_state = S_ALU;
      end
      S_ALU: begin
        shift = f.sh;
        // Single-operand forms zero the A input so the ALU passes (or inverts) B
        if (f.opcode == OPC_MOV) begin
          asel  = 1'b1;
          ALUop = ALU_ADD;
        end else if (f.op == OP_MVN) begin
          asel  = 1'b1;
          ALUop = ALU_NOTB;
        end else begin
          ALUop = f.op;
        end
        // CMP only updates status flags and never writes back
        if (f.opcode == OPC_ALU && f.op == OP_CMP) begin
          loads      = 1'b1;
          next_state = S_WAIT;
        end else begin
          loadc      = 1'b1;
          next_state = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum   = f.rd;
        vsel       = VSEL_C;
        write      = 1'b1;
        next_state = S_WAIT;
      end
      default: next_state = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Scoreboard bench: stimulus pushes per-cycle expected control vectors, a monitor compares on negedge.
// Latency: n/a.
// Backpressure: stimulus waits for w=1 before issuing the next instruction.
module tb_datapath_controller;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
  } ctl_t;

  localparam int K_MOVI = 0;
  localparam int K_MOVR = 1;
  localparam int K_MVN  = 2;
  localparam int K_ADD  = 3;
  localparam int K_CMP  = 4;
  localparam int K_AND  = 5;
  localparam int K_BAD  = 6;

  // Cycles from s edge until w returns to 1, per instruction class
  int lat_tab [7] = '{2, 4, 4, 5, 4, 5, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  ctl_t        act;
  ctl_t        exp_q [$];
  string       tag_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_ir;

  datapath_controller dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .load     (load),
    .s        (s),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  always #5 clk = ~clk;

  assign act = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                asel, bsel, shift, ALUop, sximm8, sximm5};

  // Two's-complement value of the low 'bits' bits, by plain arithmetic
  function automatic logic [15:0] sext(input int v, input int bits);
    int x;
    x = v;
    if (x >= (1 << (bits - 1))) x = x - (1 << bits);
    return 16'(x);
  endfunction

  // All controls idle; immediates reflect the given IR
  function automatic ctl_t base(input logic [15:0] ir);
    ctl_t c;
    c        = '0;
    c.sximm8 = sext(int'(ir[7:0]), 8);
    c.sximm5 = sext(int'(ir[4:0]), 5);
    return c;
  endfunction

  function automatic int kind_of(input logic [15:0] ir);
    case ({ir[15:13], ir[12:11]})
      5'b110_10: return K_MOVI;
      5'b110_00: return K_MOVR;
      5'b101_11: return K_MVN;
      5'b101_00: return K_ADD;
      5'b101_01: return K_CMP;
      5'b101_10: return K_AND;
      default:   return K_BAD;
    endcase
  endfunction

  task automatic push(input ctl_t c, input string t);
    exp_q.push_back(c);
    tag_q.push_back(t);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, starting at the cycle after the s edge
  task automatic push_program(input logic [15:0] ir);
    ctl_t c;
    int   k;
    k = kind_of(ir);
    push(base(ir), "decode");
    if (k == K_MOVI) begin
      c = base(ir); c.writenum = ir[10:8]; c.vsel = 2'b10; c.write = 1'b1;
      push(c, "write_imm");
    end else if (k != K_BAD) begin
      if (k == K_ADD || k == K_CMP || k == K_AND) begin
        c = base(ir); c.readnum = ir[10:8]; c.loada = 1'b1;
        push(c, "read_rn");
      end
      c = base(ir); c.readnum = ir[2:0]; c.loadb = 1'b1;
      push(c, "read_rm");
      c = base(ir); c.shift = ir[4:3];
      if (k == K_MOVR)     begin c.asel = 1'b1; c.aluop = 2'b00; end
      else if (k == K_MVN) begin c.asel = 1'b1; c.aluop = 2'b11; end
      else                 c.aluop = ir[12:11];
      if (k == K_CMP) c.loads = 1'b1;
      else            c.loadc = 1'b1;
      push(c, "alu");
      if (k != K_CMP) begin
        c = base(ir); c.writenum = ir[7:5]; c.vsel = 2'b00; c.write = 1'b1;
        push(c, "write_rd");
      end
    end
    c = base(ir); c.w = 1'b1;
    push(c, "back_to_idle");
  endtask

  // Enter at posedge+1 while idle. mode 0: load and s together, 1: load then s, 2: s only.
  // noisy drives random in/load/s for the whole busy period.
  task automatic issue(input logic [15:0] instr, input int mode, input bit noisy);
    ctl_t c;
    int   lat;
    c = base(model_ir); c.w = 1'b1;
    if (mode == 1) begin
      in = instr; load = 1'b1; s = 1'b0;
      push(c, "idle_load");
      @(posedge clk); #1;
      model_ir = instr;
      load = 1'b0;
      c = base(model_ir); c.w = 1'b1;
    end
    in   = instr;
    load = (mode == 0);
    s    = 1'b1;
    push(c, "idle_start");
    @(posedge clk); #1;
    if (mode == 0) model_ir = instr;
    s = 1'b0; load = 1'b0;
    push_program(model_ir);
    if (noisy) begin
      in = 16'($urandom); load = 1'b1; s = 1'b1;
    end
    lat = 0;
    @(negedge clk);
    while (!w && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    s = 1'b0; load = 1'b0;
    checks++;
    if (lat != lat_tab[kind_of(model_ir)]) begin
      errors++;
      $display("FAIL latency ir=%h: got %0d cycles want %0d", model_ir, lat, lat_tab[kind_of(model_ir)]);
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain ir=%h: %0d expected cycles left unchecked, want 0", model_ir, exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  // Monitor: one expected vector per cycle while the scoreboard holds entries
  always @(negedge clk) begin
    ctl_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s ir=%h: got %h want %h", t, model_ir, act, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    ctl_t        c;
    logic [15:0] r;
    reset = 1'b1; in = '0; load = 1'b0; s = 1'b0; model_ir = '0;
    c = base(16'h0000); c.w = 1'b1;
    push(c, "reset_state");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Directed instructions
    issue(16'hD007, 1, 1'b0);   // MOV R0,#7
    issue(16'hD1FE, 0, 1'b0);   // MOV R1,#-2
    issue(16'hA148, 1, 1'b0);   // ADD R2,R1,R0,LSL#1
    issue(16'hA801, 0, 1'b0);   // CMP R0,R1
    issue(16'hB860, 0, 1'b0);   // MVN R3,R0

    // Reset mid-sequence: ADD up to the Rn-read stage, then async reset
    in = 16'hA148; load = 1'b1; s = 1'b1;
    c = base(model_ir); c.w = 1'b1;
    push(c, "idle_start");
    @(posedge clk); #1;
    model_ir = 16'hA148;
    s = 1'b0; load = 1'b0;
    push(base(model_ir), "decode");
    c = base(model_ir); c.readnum = 3'd1; c.loada = 1'b1;
    push(c, "read_rn");
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk); #1;
    reset = 1'b1;
    model_ir = '0;
    #1;
    c = base(16'h0000); c.w = 1'b1;
    checks++;
    if (act !== c) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", act, c);
    end
    push(c, "reset_hold");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // IR is zero after reset: start without load runs an unsupported opcode
    issue(16'h1234, 2, 1'b0);

    // Busy-time load/s are ignored; rerun without load proves IR kept ADD
    issue(16'hA148, 0, 1'b1);
    issue(16'h5555, 2, 1'b0);

    // Randomized instruction mix
    for (int i = 0; i < 40; i++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: r[15:11] = 5'b110_10;
        1: r[15:11] = 5'b110_00;
        2: r[15:13] = 3'b101;
        default: ;
      endcase
      issue(r, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
